// File: rtl/result_buf_pkg.sv
// Shared definitions for the result buffer slice.
//   ptr_width(depth) : read/write pointer width for a DEPTH-entry store
//   cnt_width(depth) : occupancy counter width, able to hold 0..DEPTH
//   RESET_DATA_BIT   : value every stored bit takes on reset (all zeros)
package result_buf_pkg;

    localparam logic RESET_DATA_BIT = 1'b0;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_buffer_if.sv
// Handshake and status bundle between the array output edge, the result
// buffer and the readback consumer.
//   d_in, dob       : result word and capture strobe (producer -> buffer)
//   d_out, out_valid: head-of-FIFO word and non-empty flag (buffer -> consumer)
//   out_ready       : consumer accepts d_out this cycle
//   done            : one-cycle frame completion pulse
//   count/full/empty: occupancy status
//   ovf             : sticky overflow flag
// Modports: slave = buffer side, master = surrounding logic side.
interface result_buffer_if #(
    parameter int N     = 1,
    parameter int DEPTH = 4
) ();
    import result_buf_pkg::*;

    logic [N-1:0]                  d_in;
    logic                          dob;
    logic [N-1:0]                  d_out;
    logic                          out_valid;
    logic                          out_ready;
    logic                          done;
    logic [cnt_width(DEPTH)-1:0]   count;
    logic                          full;
    logic                          empty;
    logic                          ovf;

    modport slave (
        input  d_in, dob, out_ready,
        output d_out, out_valid, done, count, full, empty, ovf
    );

    modport master (
        output d_in, dob, out_ready,
        input  d_out, out_valid, done, count, full, empty, ovf
    );

endinterface

// File: rtl/frame_counter.sv
// Counts accepted words within a result frame and pulses done for one cycle
// after the frame's last word is accepted.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   inc   : one word accepted this cycle
//   done  : registered; high in the cycle after the FRAME_LEN-th increment
module frame_counter #(
    parameter int FRAME_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic done
);

    // Width holds 0..FRAME_LEN so FRAME_LEN=1 still gets a 1-bit counter.
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/result_buffer.sv
// Capture buffer for systolic-array result words: a DEPTH-entry circular
// FIFO with show-ahead output, per-frame done pulse and occupancy status.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset; clears storage, pointers, status
//   bus   : result_buffer_if slave modport (d_in/dob in, d_out/out_valid/
//           out_ready handshake out, done, count, full, empty, ovf)
// Build option: define RESULT_BUF_OVF_EN to make ovf a sticky flag set by a
// write dropped while full; otherwise ovf is tied low.
module result_buffer
    import result_buf_pkg::*;
#(
    parameter int N         = 1,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    result_buffer_if.slave  bus
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          pop;
    logic          push;

    assign pop  = !empty_q && bus.out_ready;
    // A write into a full buffer only fits if the head leaves this cycle.
    assign push = bus.dob && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {N{RESET_DATA_BIT}};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= bus.d_in;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign bus.d_out     = mem[rd_ptr_q];
    assign bus.out_valid = !empty_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;

`ifdef RESULT_BUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (bus.dob && full_q && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .done  (bus.done)
    );

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer (N=8, DEPTH=4, FRAME_LEN=3).
// A queue-based model tracks expected contents, frame progress and flags;
// a negedge process compares every output against it, and directed steps
// add hand-computed literal checks.
module tb_result_buffer;

    localparam int N         = 8;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    result_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    result_buffer #(
        .N         (N),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef RESULT_BUF_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] mq[$];
    int           m_frame  = 0;
    logic         m_done   = 1'b0;
    logic         m_ovf    = 1'b0;
    bit           m_active = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_frame  = 0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_active = 1;
        end else if (m_active) begin
            bit did_pop;
            bit did_push;
            did_pop  = (mq.size() > 0) && bus.out_ready;
            did_push = bus.dob && ((mq.size() < DEPTH) || did_pop);
            if (bus.dob && mq.size() == DEPTH && !did_pop && OVF_ON) m_ovf = 1'b1;
            m_done = 1'b0;
            if (did_pop) void'(mq.pop_front());
            if (did_push) begin
                mq.push_back(bus.d_in);
                m_frame++;
                if (m_frame == FRAME_LEN) begin
                    m_frame = 0;
                    m_done  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_active) begin
            check("count",     32'(bus.count),     32'(mq.size()));
            check("empty",     32'(bus.empty),     32'(mq.size() == 0));
            check("full",      32'(bus.full),      32'(mq.size() == DEPTH));
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            check("done",      32'(bus.done),      32'(m_done));
            check("ovf",       32'(bus.ovf),       32'(m_ovf));
            if (mq.size() != 0) check("d_out", 32'(bus.d_out), 32'(mq[0]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic d, input logic [N-1:0] w, input logic r);
        bus.dob       = d;
        bus.d_in      = w;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},     32'(bus.count),     32'd0);
        check({tag, "_empty"},     32'(bus.empty),     32'd1);
        check({tag, "_full"},      32'(bus.full),      32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
        check({tag, "_d_out"},     32'(bus.d_out),     32'd0);
    endtask

    initial begin
        logic [N-1:0] fill [4];
        logic [N-1:0] drain_exp [4];
        logic [N-1:0] post [3];
        logic [6:0]   dmask;
        fill      = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_exp = '{8'h22, 8'h33, 8'h44, 8'h55};
        post      = '{8'hC1, 8'hC2, 8'hC3};

        // Reset then idle.
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        check_reset_state("rst");
        step(1'b0, 8'h00, 1'b0);
        check_reset_state("idle");

        // Fill with out_ready low; third push closes the first frame.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fill[i], 1'b0);
            check("fill_done", 32'(bus.done), (i == 2) ? 32'd1 : 32'd0);
            check("fill_head", 32'(bus.d_out), 32'h11);
        end
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_full",  32'(bus.full),  32'd1);

        // Write while full without pop: dropped.
        step(1'b1, 8'h55, 1'b0);
        check("drop_count", 32'(bus.count), 32'd4);
        check("drop_ovf",   32'(bus.ovf),   32'(OVF_ON));
        check("drop_head",  32'(bus.d_out), 32'h11);

        // Write while full with pop: accepted, 0x11 leaves.
        step(1'b1, 8'h55, 1'b1);
        check("pp_count", 32'(bus.count), 32'd4);
        check("pp_full",  32'(bus.full),  32'd1);

        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(bus.d_out), 32'(drain_exp[i]));
            step(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_ovf_sticky", 32'(bus.ovf), 32'(OVF_ON));

        // Clean frame alignment, then 7 pushes with continuous drain.
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        check("rst2_ovf", 32'(bus.ovf), 32'd0);
        dmask = '0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b1);
            dmask[i] = bus.done;
        end
        check("frame_done_mask", 32'(dmask), 32'b0100100);
        step(1'b0, 8'h00, 1'b1);
        check("frame_tail_done", 32'(bus.done), 32'd0);
        check("frame_tail_empty", 32'(bus.empty), 32'd1);

        // Reset after 2 of 3 frame words.
        step(1'b1, 8'hB1, 1'b0);
        step(1'b1, 8'hB2, 1'b0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        check_reset_state("midrst");
        dmask = '0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, post[i], 1'b0);
            dmask[i] = bus.done;
        end
        step(1'b0, 8'h00, 1'b0);
        dmask[3] = bus.done;
        check("midrst_done_mask", 32'(dmask), 32'b0000100);
        for (int i = 0; i < 3; i++) begin
            check("midrst_order", 32'(bus.d_out), 32'(post[i]));
            step(1'b0, 8'h00, 1'b1);
        end
        check("midrst_empty", 32'(bus.empty), 32'd1);

        step(1'b0, 8'h00, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
